time_capture_ctrl: RTL and testbench

- Upstream feeder of the time-domain display memory port (enaTime/weaTime/addraTime/dinaTime) in the ck100MHz domain.
- On each frame request it waits for a rising-edge trigger in the audio sample stream (auto-triggers on timeout) and decimates samples.
- Converts each sample to an 8-bit display height and writes NUM_POINTS consecutive words from address 0, one per horizontal pixel column.

---
 rtl/time_capture_pkg.sv | 31 +++
 rtl/time_capture_ctrl_sample_to_display.sv | 69 ++++++
 rtl/time_capture_ctrl.sv | 146 ++++++++++++++
 tb/tb_time_capture_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_capture_pkg
// Brief    : Shared types, widths and sample-to-display conversion helper.
// Revision : 1.0
// ============================================================================
package time_capture_pkg;

    localparam int DISP_ADDR_W = 10;
    localparam int DISP_DATA_W = 8;
    localparam int SAMPLE_W    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Offset-binary upper byte of a signed sample, clamped to the display height.
    function automatic logic [DISP_DATA_W-1:0] to_disp(input logic [SAMPLE_W-1:0] s,
                                                       input logic [DISP_DATA_W-1:0] max_v);
        logic [SAMPLE_W-1:0]    w;
        logic [DISP_DATA_W-1:0] u;
        w = s ^ 16'h8000;
        u = DISP_DATA_W'(w >> 8);
        return (u > max_v) ? max_v : u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_capture_ctrl_sample_to_display.sv
`default_nettype none
// ============================================================================
// Module   : sample_to_display
// Brief    : Produces the registered display write word from the sample stream.
//            TIME_CAPTURE_AVERAGE_EN selects box-car averaging over DECIM samples.
// Revision : 1.0
// ============================================================================
module sample_to_display
    import time_capture_pkg::*;
#(
    parameter int DECIM    = 4,
    parameter int DISP_MAX = 239,
    parameter int DCNT_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic                       i_vld,
    input  logic [DCNT_W-1:0]          i_pos,
    output logic                       o_word,
    output logic                       o_wr,
    output logic [DISP_DATA_W-1:0]     o_data
);

    logic [SAMPLE_W-1:0] w_value;

`ifdef TIME_CAPTURE_AVERAGE_EN
    localparam int LOG2  = $clog2(DECIM);
    localparam int ACC_W = SAMPLE_W + LOG2;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_sum;

    // Group starts at position 0; the word is emitted with the last group member.
    always_comb begin
        w_ext   = ACC_W'(i_sample);
        w_sum   = (i_pos == '0) ? w_ext : r_acc + w_ext;
        w_value = SAMPLE_W'(w_sum >>> LOG2);
    end

    assign o_word = i_vld && (i_pos == DCNT_W'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_vld) begin
            r_acc <= w_sum;
        end
    end
`else
    assign w_value = i_sample;
    assign o_word  = i_vld && (i_pos == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_wr   <= 1'b0;
            o_data <= '0;
        end else begin
            o_wr <= o_word;
            if (o_word) begin
                o_data <= to_disp(w_value, DISP_DATA_W'(DISP_MAX));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/time_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_capture_ctrl
// Brief    : Triggered, decimated capture of audio samples into the time-domain
//            display memory. Honours TIME_CAPTURE_AVERAGE_EN via sample_to_display.
// Revision : 1.0
// ============================================================================
module time_capture_ctrl
    import time_capture_pkg::*;
#(
    parameter int                          NUM_POINTS   = 640,
    parameter int                          DECIM        = 4,
    parameter logic signed [SAMPLE_W-1:0]  TRIG_LEVEL   = '0,
    parameter int                          TRIG_TIMEOUT = 4096,
    parameter int                          DISP_MAX     = 239
) (
    input  logic                       ck100MHz,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_vld,
    input  logic                       frame_req,
    output logic                       enaTime,
    output logic                       weaTime,
    output logic [DISP_ADDR_W-1:0]     addraTime,
    output logic [DISP_DATA_W-1:0]     dinaTime,
    output logic                       busy,
    output logic                       done,
    output logic                       trig_auto
);

    localparam int DCNT_W = $clog2(DECIM) + 1;

    state_t                       r_state;
    logic signed [SAMPLE_W-1:0]   r_prev;
    logic [15:0]                  r_tcnt;
    logic [DCNT_W-1:0]            r_dcnt;
    logic [DISP_ADDR_W-1:0]       r_widx;
    logic [DISP_ADDR_W-1:0]       r_addr;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_auto;

    logic                         w_level;
    logic                         w_timeout;
    logic                         w_trig;
    logic                         w_cap_vld;
    logic [DCNT_W-1:0]            w_pos;
    logic                         w_pos_last;
    logic                         w_word;
    logic                         w_wr;
    logic                         w_last_word;

    assign w_level     = (r_prev < TRIG_LEVEL) && (sample_in >= TRIG_LEVEL);
    assign w_timeout   = (r_tcnt == 16'(TRIG_TIMEOUT - 1));
    assign w_trig      = (r_state == WAIT_TRIG) && sample_vld && (w_level || w_timeout);
    // The triggering sample is group position 0 of the capture.
    assign w_cap_vld   = sample_vld && ((r_state == CAPTURE) || w_trig);
    assign w_pos       = w_trig ? '0 : r_dcnt;
    assign w_pos_last  = (w_pos == DCNT_W'(DECIM - 1));
    assign w_last_word = w_word && (r_widx == DISP_ADDR_W'(NUM_POINTS - 1));

    sample_to_display #(
        .DECIM    (DECIM),
        .DISP_MAX (DISP_MAX),
        .DCNT_W   (DCNT_W)
    ) u_s2d (
        .clk      (ck100MHz),
        .rst      (rst),
        .i_sample (sample_in),
        .i_vld    (w_cap_vld),
        .i_pos    (w_pos),
        .o_word   (w_word),
        .o_wr     (w_wr),
        .o_data   (dinaTime)
    );

    always_ff @(posedge ck100MHz) begin
        if (rst) begin
            r_state <= IDLE;
            r_prev  <= '0;
            r_tcnt  <= '0;
            r_dcnt  <= '0;
            r_widx  <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_auto  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (sample_vld) begin
                r_prev <= sample_in;
            end
            if (w_word) begin
                r_addr <= r_widx;
                r_widx <= r_widx + 1'b1;
            end
            if (w_cap_vld) begin
                r_dcnt <= w_pos_last ? '0 : w_pos + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (frame_req) begin
                        r_state <= WAIT_TRIG;
                        r_busy  <= 1'b1;
                        r_tcnt  <= '0;
                        r_auto  <= 1'b0;
                        r_widx  <= '0;
                    end
                end
                WAIT_TRIG: begin
                    if (sample_vld) begin
                        if (w_level) begin
                            r_state <= CAPTURE;
                        end else if (w_timeout) begin
                            r_state <= CAPTURE;
                            r_auto  <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + 16'd1;
                        end
                    end
                end
                CAPTURE: begin
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            // DONE is occupied during the final write strobe; the pulse follows it.
            if (w_last_word) begin
                r_state <= DONE;
            end
        end
    end

    assign enaTime   = w_wr;
    assign weaTime   = w_wr;
    assign addraTime = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign trig_auto = r_auto;

endmodule
`default_nettype wire

// File: tb/tb_time_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_capture_ctrl
// Brief    : Self-checking bench: conversion table, randomized captures against a
//            sample-list reference model, and reset / re-request corner sequences.
// Revision : 1.0
// ============================================================================
module tb_time_capture_ctrl;

    localparam int NP0  = 8;
    localparam int DEC0 = 4;
    localparam int NP1  = 1;
    localparam int DEC1 = 1;
    localparam int TO   = 16;
    localparam int TL   = 0;
    localparam int DMAX = 239;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        req0;
    logic        req1;
    logic [15:0] smp;

    logic       ena0, wea0, busy0, done0, auto0;
    logic [9:0] addr0;
    logic [7:0] din0;
    logic       ena1, wea1, busy1, done1, auto1;
    logic [9:0] addr1;
    logic [7:0] din1;

    time_capture_ctrl #(
        .NUM_POINTS(NP0), .DECIM(DEC0), .TRIG_LEVEL(16'sd0),
        .TRIG_TIMEOUT(TO), .DISP_MAX(DMAX)
    ) dut0 (
        .ck100MHz(clk), .rst(rst), .sample_in(smp), .sample_vld(vld), .frame_req(req0),
        .enaTime(ena0), .weaTime(wea0), .addraTime(addr0), .dinaTime(din0),
        .busy(busy0), .done(done0), .trig_auto(auto0)
    );

    time_capture_ctrl #(
        .NUM_POINTS(NP1), .DECIM(DEC1), .TRIG_LEVEL(16'sd0),
        .TRIG_TIMEOUT(TO), .DISP_MAX(DMAX)
    ) dut1 (
        .ck100MHz(clk), .rst(rst), .sample_in(smp), .sample_vld(vld), .frame_req(req1),
        .enaTime(ena1), .weaTime(wea1), .addraTime(addr1), .dinaTime(din1),
        .busy(busy1), .done(done1), .trig_auto(auto1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        logic [15:0] pre;
        logic [15:0] smp;
        int          exp_data;
        int          exp_auto;
    } vec_t;

    wr_t         log0[$];
    wr_t         log1[$];
    int          dn0[$];
    int          dn1[$];
    int          bc0, bc1, eb0, eb1;
    int          sv[$];
    int          sc[$];
    logic [15:0] pre_q[$];
    int          prev0_run;
    int          last_smp;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        wr_t w;
        if (wea0) begin
            w.addr = int'(addr0); w.data = int'(din0); w.cyc = cyc;
            log0.push_back(w);
        end
        if (wea1) begin
            w.addr = int'(addr1); w.data = int'(din1); w.cyc = cyc;
            log1.push_back(w);
        end
        if (done0) dn0.push_back(cyc);
        if (done1) dn1.push_back(cyc);
        if (busy0) bc0++;
        if (busy1) bc1++;
        if (ena0 !== wea0) eb0++;
        if (ena1 !== wea1) eb1++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int disp(input int v);
        int u;
        u = (v + 32768) / 256;
        return (u > DMAX) ? DMAX : u;
    endfunction

    task automatic send(input logic v, input logic [15:0] s, input logic r0, input logic r1,
                        output int c);
        @(negedge clk);
        vld  = v;
        smp  = s;
        req0 = r0;
        req1 = r1;
        c    = cyc;
        if (v) last_smp = int'($signed(s));
    endtask

    // Reference: scan accepted samples for the trigger, then form words from the list.
    task automatic check_dut(input int d, input int np, input int dec, input int rc);
        int  trig, auto_e, nw, idx0, idx, sum, mean, last_c, ndn, bc, eb, au;
        wr_t w;
        trig = -1; auto_e = 0; last_c = rc;
        for (int i = 0; i < sv.size(); i++) begin
            int p;
            p = (i == 0) ? prev0_run : sv[i-1];
            if (p < TL && sv[i] >= TL) begin trig = i; break; end
            if (i == TO - 1) begin trig = i; auto_e = 1; break; end
        end
        nw  = (d == 0) ? log0.size() : log1.size();
        ndn = (d == 0) ? dn0.size() : dn1.size();
        bc  = (d == 0) ? bc0 : bc1;
        eb  = (d == 0) ? eb0 : eb1;
        au  = (d == 0) ? int'(auto0) : int'(auto1);
        chk($sformatf("dut%0d_wr_count", d), nw, np);
        if (trig < 0) begin
            chk($sformatf("dut%0d_trigger_seen", d), 0, 1);
            return;
        end
        for (int k = 0; k < np && k < nw; k++) begin
            idx0 = trig + k * dec;
`ifdef TIME_CAPTURE_AVERAGE_EN
            idx = idx0 + dec - 1;
            if (idx >= sv.size()) begin chk("model_samples", 0, 1); break; end
            sum = 0;
            for (int j = 0; j < dec; j++) sum += sv[idx0 + j];
            mean = (sum >= 0) ? sum / dec : -((-sum + dec - 1) / dec);
`else
            idx = idx0;
            if (idx >= sv.size()) begin chk("model_samples", 0, 1); break; end
            mean = sv[idx];
`endif
            w = (d == 0) ? log0[k] : log1[k];
            chk($sformatf("dut%0d_addr[%0d]", d, k), w.addr, k);
            chk($sformatf("dut%0d_data[%0d]", d, k), w.data, disp(mean));
            chk($sformatf("dut%0d_wr_cyc[%0d]", d, k), w.cyc, sc[idx] + 1);
            last_c = sc[idx] + 1;
        end
        chk($sformatf("dut%0d_done_count", d), ndn, 1);
        if (ndn > 0) chk($sformatf("dut%0d_done_cyc", d), (d == 0) ? dn0[0] : dn1[0], last_c + 1);
        chk($sformatf("dut%0d_trig_auto", d), au, auto_e);
        chk($sformatf("dut%0d_busy_cycles", d), bc, last_c - rc);
        chk($sformatf("dut%0d_ena_eq_wea", d), eb, 0);
    endtask

    // mode 0 random, 1 ramp from -8, 2 constant, 3 preset queue then random.
    task automatic run(input int mode, input logic [15:0] cval, input bit u0, input bit u1,
                       input bit extra);
        int          c, rc, gap, n, tail, budget;
        bit          xdone;
        logic        r0;
        logic [15:0] v;
        log0.delete(); log1.delete(); dn0.delete(); dn1.delete();
        bc0 = 0; bc1 = 0; eb0 = 0; eb1 = 0;
        sv.delete(); sc.delete();
        prev0_run = last_smp;
        send(1'b0, smp, u0, u1, rc);
        gap = 1; n = 0; tail = 0; budget = 0; xdone = 1'b0;
        while (tail < 4 && budget < 3000) begin
            r0 = 1'b0;
            if (extra && !xdone && log0.size() == 2) begin r0 = 1'b1; xdone = 1'b1; end
            if (gap == 0) begin
                case (mode)
                    1:       v = 16'(n - 8);
                    2:       v = cval;
                    3:       v = (n < pre_q.size()) ? pre_q[n] : 16'($urandom);
                    default: v = 16'($urandom);
                endcase
                send(1'b1, v, r0, 1'b0, c);
                sv.push_back(int'($signed(v)));
                sc.push_back(c);
                n++;
                gap = $urandom_range(1, 3);
            end else begin
                send(1'b0, smp, r0, 1'b0, c);
                gap--;
            end
            if ((!u0 || dn0.size() > 0) && (!u1 || dn1.size() > 0)) tail++;
            budget++;
        end
        if (tail < 4) chk("run_budget", 0, 1);
        if (u0) check_dut(0, NP0, DEC0, rc);
        if (u1) check_dut(1, NP1, DEC1, rc);
    endtask

    vec_t tbl[8];

    initial begin
        int c, budget, k;
        tbl[0] = '{16'h0000, 16'h7FFF, 239, 1};
        tbl[1] = '{16'h7FFF, 16'h8000, 0,   1};
        tbl[2] = '{16'h8000, 16'h0000, 128, 0};
        tbl[3] = '{16'h0000, 16'hFFFF, 127, 1};
        tbl[4] = '{16'hFFFF, 16'h6F00, 239, 0};
        tbl[5] = '{16'h0000, 16'h7000, 239, 1};
        tbl[6] = '{16'h0000, 16'hC000, 64,  1};
        tbl[7] = '{16'hC000, 16'h1000, 144, 0};

        rst = 1'b1; vld = 1'b0; req0 = 1'b0; req1 = 1'b0; smp = '0; last_smp = 0;
        repeat (3) @(negedge clk);
        chk("rst_ena",   int'(ena0),  0);
        chk("rst_wea",   int'(wea0),  0);
        chk("rst_addr",  int'(addr0), 0);
        chk("rst_din",   int'(din0),  0);
        chk("rst_busy",  int'(busy0), 0);
        chk("rst_done",  int'(done0), 0);
        chk("rst_auto",  int'(auto0), 0);
        chk("rst_busy1", int'(busy1), 0);
        rst = 1'b0;

        // Ramp through zero: level trigger, every word maps to mid-scale.
        run(1, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("ramp_auto", int'(auto0), 0);
        if (log0.size() > 7) chk("ramp_last_data", log0[7].data, 128);

        // Constant positive input never crosses the level: auto-trigger.
        send(1'b1, 16'h1000, 1'b0, 1'b0, c);
        run(2, 16'h1000, 1'b1, 1'b1, 1'b0);
        chk("const_auto", int'(auto0), 1);
        if (log0.size() > 0) chk("const_data", log0[0].data, 144);

        for (int i = 0; i < 8; i++) begin
            send(1'b1, tbl[i].pre, 1'b0, 1'b0, c);
            run(2, tbl[i].smp, 1'b0, 1'b1, 1'b0);
            if (log1.size() > 0) chk($sformatf("tbl%0d_data", i), log1[0].data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_auto", i), int'(auto1), tbl[i].exp_auto);
        end

        // Group of known samples right after a level trigger.
        pre_q = '{16'h0100, 16'h0300, 16'h0500, 16'h0700};
        send(1'b1, 16'hFFFF, 1'b0, 1'b0, c);
        run(3, 16'h0000, 1'b1, 1'b1, 1'b0);
`ifdef TIME_CAPTURE_AVERAGE_EN
        if (log0.size() > 0) chk("group_data", log0[0].data, 132);
`else
        if (log0.size() > 0) chk("group_data", log0[0].data, 129);
`endif

        // Re-request while capturing is ignored.
        run(0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // Reset landing on the address-3 write strobe.
        log0.delete(); dn0.delete();
        send(1'b0, smp, 1'b1, 1'b0, c);
        budget = 0; k = 0;
        while (!(wea0 && addr0 == 10'd3) && budget < 600) begin
            if (budget % 2 == 0) begin
                send(1'b1, 16'(k - 8), 1'b0, 1'b0, c);
                k++;
            end else begin
                send(1'b0, smp, 1'b0, 1'b0, c);
            end
            budget++;
        end
        chk("rst_seq_reached_addr3", int'(wea0 && addr0 == 10'd3), 1);
        rst = 1'b1; vld = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", int'(busy0), 0);
        chk("rst_mid_wea",  int'(wea0),  0);
        chk("rst_mid_done", int'(done0), 0);
        rst = 1'b0; last_smp = 0;
        repeat (3) send(1'b0, smp, 1'b0, 1'b0, c);
        chk("rst_no_done", dn0.size(), 0);
        run(1, 16'h0000, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) run(0, 16'h0000, 1'b1, 1'b1, (i == 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
